// File: rtl/sram_responder_model_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// sram_responder_model_if: SRAM pin bus (address and strobes), rev 1.0
//------------------------------------------------------------------------------
interface sram_responder_model_if;
  logic [19:0] addr;
  logic        we_n;
  logic        ce_n;
  logic        oe_n;
  logic        lb_n;
  logic        ub_n;

  modport master (output addr, we_n, ce_n, oe_n, lb_n, ub_n);
  modport slave  (input  addr, we_n, ce_n, oe_n, lb_n, ub_n);
endinterface
`default_nettype wire

// File: rtl/sram_responder_model.sv
`default_nettype none
//------------------------------------------------------------------------------
// sram_responder_model: 16-bit async SRAM device model with stats, rev 1.0
//------------------------------------------------------------------------------
module sram_responder_model #(
  parameter int          DEPTH    = 12288,
  parameter int          READ_LAT = 0,
  parameter logic [15:0] OOB_DATA = 16'h0000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  sram_responder_model_if.slave  sram,
  inout  wire  [15:0]            io_SRAM_DQ,
  input  logic                   i_clr_status,
  output logic [20:0]            o_wr_count,
  output logic [20:0]            o_rd_count,
  output logic                   o_oob,
  output logic                   o_lane_err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [20:0] DEPTH_W = 21'(DEPTH);
  localparam logic [20:0] CNT_MAX = {21{1'b1}};

  // Separate byte-lane arrays keep partial writes a plain per-lane store.
  logic [7:0] mem_lo [DEPTH];
  logic [7:0] mem_hi [DEPTH];

  logic          access;
  logic          wr_acc;
  logic          rd_acc;
  logic          in_range;
  logic          lane_none;
  logic [AW-1:0] idx;
  logic [15:0]   rdata;
  logic [15:0]   out_data;
  logic          out_lo;
  logic          out_hi;
  logic          out_vld;
  logic          drive;

  logic [20:0]   wr_cnt;
  logic [20:0]   rd_cnt;
  logic          oob;
  logic          lane_err;

  assign access    = !sram.ce_n;
  assign wr_acc    = access && !sram.we_n;
  assign rd_acc    = access && sram.we_n;
  assign in_range  = {1'b0, sram.addr} < DEPTH_W;
  assign idx       = sram.addr[AW-1:0];
  assign lane_none = sram.lb_n && sram.ub_n;
  assign rdata     = in_range ? {mem_hi[idx], mem_lo[idx]} : OOB_DATA;

  always_ff @(posedge i_clk) begin
    if (i_rst_n && wr_acc && in_range) begin
      if (!sram.lb_n) mem_lo[idx] <= io_SRAM_DQ[7:0];
      if (!sram.ub_n) mem_hi[idx] <= io_SRAM_DQ[15:8];
    end
  end

  // Clear shares the reset path so it wins over a same-cycle update.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr_status) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      oob      <= 1'b0;
      lane_err <= 1'b0;
    end else begin
      if (wr_acc && (wr_cnt != CNT_MAX)) wr_cnt <= wr_cnt + 21'd1;
      if (rd_acc && (rd_cnt != CNT_MAX)) rd_cnt <= rd_cnt + 21'd1;
      if (access && !in_range)           oob      <= 1'b1;
      if (access && lane_none)           lane_err <= 1'b1;
    end
  end

  assign o_wr_count = wr_cnt;
  assign o_rd_count = rd_cnt;
  assign o_oob      = oob;
  assign o_lane_err = lane_err;

  if (READ_LAT == 0) begin : g_async
    assign out_data = rdata;
    assign out_lo   = !sram.lb_n;
    assign out_hi   = !sram.ub_n;
    assign out_vld  = 1'b1;
  end else begin : g_pipe
    logic [15:0]         pdata [READ_LAT];
    logic [READ_LAT-1:0] pvld;
    logic [READ_LAT-1:0] plo;
    logic [READ_LAT-1:0] phi;

    // Valid bits carry the reset so in-flight reads vanish at a reset edge.
    always_ff @(posedge i_clk) begin
      pvld[0]  <= i_rst_n && rd_acc;
      pdata[0] <= rdata;
      plo[0]   <= !sram.lb_n;
      phi[0]   <= !sram.ub_n;
      for (int s = 1; s < READ_LAT; s++) begin
        pvld[s]  <= i_rst_n && pvld[s-1];
        pdata[s] <= pdata[s-1];
        plo[s]   <= plo[s-1];
        phi[s]   <= phi[s-1];
      end
    end

    assign out_data = pdata[READ_LAT-1];
    assign out_lo   = plo[READ_LAT-1];
    assign out_hi   = phi[READ_LAT-1];
    assign out_vld  = pvld[READ_LAT-1];
  end

  // Only drive while the controller is itself in a read cycle.
  assign drive = i_rst_n && rd_acc && !sram.oe_n && out_vld;

  assign io_SRAM_DQ[7:0]  = (drive && out_lo) ? out_data[7:0]  : 8'hzz;
  assign io_SRAM_DQ[15:8] = (drive && out_hi) ? out_data[15:8] : 8'hzz;

endmodule
`default_nettype wire
